// File: rtl/morse_row_builder.sv
// -----------------------------------------------------------------------------
// morse_row_builder
//   Front end for the 16x2 LCD driver. A single pushbutton is synchronised,
//   debounced and timed in 1 ms ticks; each press is classified as a dot or a
//   dash, a released pause commits the pending symbols as one ASCII character
//   (A-Z, 0-9, '?' for anything else) and a longer pause inserts a space.
//   Characters land in a 32-cell text buffer presented as two 16-char rows.
//
// Optional feature: define MORSE_SCROLL_EN to scroll row 2 into row 1 when the
//   buffer fills; otherwise the cursor wraps to cell 0 and the next character
//   blanks the whole display before it is written.
//
// Ports
//   iCLK_50MHZ   in   1    50 MHz clock
//   iRST_N       in   1    asynchronous reset, active-low
//   iKEY_N       in   1    raw pushbutton, active-low, asynchronous
//   iCLEAR       in   1    synchronous pulse: blank buffer, cursor 0, drop symbols
//   row1         out  128  line 1 text, cell 0 in [7:0]
//   row2         out  128  line 2 text, cell 16 in [7:0]
//   oCHAR        out  8    last committed ASCII character
//   oCHAR_VALID  out  1    one-cycle pulse per committed character (incl. space)
//   oCURSOR      out  5    next cell to be written, 0..31
// -----------------------------------------------------------------------------
module morse_row_builder #(
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE_MS = 10,
  parameter int DOT_MAX_MS  = 200,
  parameter int CHAR_GAP_MS = 400,
  parameter int WORD_GAP_MS = 1000
) (
  input  logic         iCLK_50MHZ,
  input  logic         iRST_N,
  input  logic         iKEY_N,
  input  logic         iCLEAR,
  output logic [127:0] row1,
  output logic [127:0] row2,
  output logic [7:0]   oCHAR,
  output logic         oCHAR_VALID,
  output logic [4:0]   oCURSOR
);

  localparam int            TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [15:0]   DEB_LAST    = 16'(DEBOUNCE_MS - 1);
  localparam logic [15:0]   DOT_MAX     = 16'(DOT_MAX_MS);
  localparam logic [15:0]   CHAR_GAP    = 16'(CHAR_GAP_MS);
  localparam logic [15:0]   WORD_GAP    = 16'(WORD_GAP_MS);
  localparam logic [7:0]    ASCII_SPACE = 8'h20;
  localparam logic [7:0]    ASCII_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_GAP    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Symbols are stored with the first entered symbol in bit 0. The lookup
  // re-orders them so the first symbol is the most significant bit, which lets
  // the table below read like ordinary Morse notation (dot=0, dash=1).
  function automatic logic [7:0] morse_decode(input logic [4:0] pat,
                                              input logic [2:0] len,
                                              input logic       ovf);
    logic [4:0] key;
    logic [7:0] ch;
    key = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      if (i < int'(len)) begin
        key = {key[3:0], pat[i]};
      end else begin
        key = key;
      end
    end
    case ({len, key})
      {3'd2, 5'b00001}: ch = 8'h41; // A .-
      {3'd4, 5'b01000}: ch = 8'h42; // B -...
      {3'd4, 5'b01010}: ch = 8'h43; // C -.-.
      {3'd3, 5'b00100}: ch = 8'h44; // D -..
      {3'd1, 5'b00000}: ch = 8'h45; // E .
      {3'd4, 5'b00010}: ch = 8'h46; // F ..-.
      {3'd3, 5'b00110}: ch = 8'h47; // G --.
      {3'd4, 5'b00000}: ch = 8'h48; // H ....
      {3'd2, 5'b00000}: ch = 8'h49; // I ..
      {3'd4, 5'b00111}: ch = 8'h4A; // J .---
      {3'd3, 5'b00101}: ch = 8'h4B; // K -.-
      {3'd4, 5'b00100}: ch = 8'h4C; // L .-..
      {3'd2, 5'b00011}: ch = 8'h4D; // M --
      {3'd2, 5'b00010}: ch = 8'h4E; // N -.
      {3'd3, 5'b00111}: ch = 8'h4F; // O ---
      {3'd4, 5'b00110}: ch = 8'h50; // P .--.
      {3'd4, 5'b01101}: ch = 8'h51; // Q --.-
      {3'd3, 5'b00010}: ch = 8'h52; // R .-.
      {3'd3, 5'b00000}: ch = 8'h53; // S ...
      {3'd1, 5'b00001}: ch = 8'h54; // T -
      {3'd3, 5'b00001}: ch = 8'h55; // U ..-
      {3'd4, 5'b00001}: ch = 8'h56; // V ...-
      {3'd3, 5'b00011}: ch = 8'h57; // W .--
      {3'd4, 5'b01001}: ch = 8'h58; // X -..-
      {3'd4, 5'b01011}: ch = 8'h59; // Y -.--
      {3'd4, 5'b01100}: ch = 8'h5A; // Z --..
      {3'd5, 5'b11111}: ch = 8'h30; // 0 -----
      {3'd5, 5'b01111}: ch = 8'h31; // 1 .----
      {3'd5, 5'b00111}: ch = 8'h32; // 2 ..---
      {3'd5, 5'b00011}: ch = 8'h33; // 3 ...--
      {3'd5, 5'b00001}: ch = 8'h34; // 4 ....-
      {3'd5, 5'b00000}: ch = 8'h35; // 5 .....
      {3'd5, 5'b10000}: ch = 8'h36; // 6 -....
      {3'd5, 5'b11000}: ch = 8'h37; // 7 --...
      {3'd5, 5'b11100}: ch = 8'h38; // 8 ---..
      {3'd5, 5'b11110}: ch = 8'h39; // 9 ----.
      default:          ch = ASCII_QMARK;
    endcase
    if (ovf) begin
      ch = ASCII_QMARK;
    end else begin
      ch = ch;
    end
    return ch;
  endfunction

  logic          key_meta_r;
  logic          key_sync_r;
  logic          key_down_s;
  logic [TW-1:0] tick_cnt_r;
  logic          tick_r;
  logic          key_db_r;      // debounced level, 1 = pressed
  logic [15:0]   db_cnt_r;
  logic [15:0]   ms_r;
  logic [15:0]   ms_next_s;
  logic [15:0]   dur_r;         // length of the press just released, in ms

  state_t        state_r;
  logic [4:0]    pat_r;
  logic [2:0]    len_r;
  logic          ovf_r;
  logic          space_armed_r;
  logic          wipe_r;        // buffer wrapped: next commit blanks both rows first
  logic [4:0]    cursor_r;
  logic [7:0]    char_r;
  logic          valid_r;
  logic [7:0]    cell_r [32];

  logic          commit_en_s;
  logic [7:0]    commit_char_s;

  assign key_down_s = ~key_sync_r;

  // Two-flop synchroniser for the asynchronous pushbutton (idle level high).
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
    end else begin
      key_meta_r <= iKEY_N;
      key_sync_r <= key_meta_r;
    end
  end

  // 1 ms tick generator: one-cycle pulse every TICK_DIV clocks.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b0;
    end else if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r + 1'b1;
      tick_r     <= 1'b0;
    end
  end

  // Saturating increment of the millisecond timer.
  always_comb begin
    if (ms_r != 16'hFFFF) begin
      ms_next_s = ms_r + 16'd1;
    end else begin
      ms_next_s = ms_r;
    end
  end

  // Debouncer and millisecond timer; the timer restarts on every accepted edge
  // and the press length is captured at the moment the release is accepted.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      key_db_r <= 1'b0;
      db_cnt_r <= 16'd0;
      ms_r     <= 16'd0;
      dur_r    <= 16'd0;
    end else if (tick_r) begin
      if (key_down_s != key_db_r) begin
        if (db_cnt_r == DEB_LAST) begin
          key_db_r <= key_down_s;
          db_cnt_r <= 16'd0;
          ms_r     <= 16'd0;
          if (!key_down_s) begin
            dur_r <= ms_r;
          end else begin
            dur_r <= dur_r;
          end
        end else begin
          db_cnt_r <= db_cnt_r + 16'd1;
          ms_r     <= ms_next_s;
        end
      end else begin
        db_cnt_r <= 16'd0;
        ms_r     <= ms_next_s;
      end
    end else begin
      ms_r <= ms_r;
    end
  end

  // Decide whether a character is committed this cycle and which one.
  always_comb begin
    commit_en_s   = 1'b0;
    commit_char_s = ASCII_SPACE;
    case (state_r)
      ST_COMMIT: begin
        commit_en_s   = 1'b1;
        commit_char_s = morse_decode(pat_r, len_r, ovf_r);
      end
      ST_IDLE: begin
        if (!key_db_r && (ms_r == WORD_GAP) && space_armed_r) begin
          commit_en_s = 1'b1;
        end else begin
          commit_en_s = 1'b0;
        end
      end
      default: begin
        commit_en_s = 1'b0;
      end
    endcase
  end

  // Main FSM: symbol collection, text buffer writes and registered outputs.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r       <= ST_IDLE;
      pat_r         <= 5'd0;
      len_r         <= 3'd0;
      ovf_r         <= 1'b0;
      space_armed_r <= 1'b0;
      wipe_r        <= 1'b0;
      cursor_r      <= 5'd0;
      char_r        <= 8'h00;
      valid_r       <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        cell_r[i] <= ASCII_SPACE;
      end
    end else begin
      valid_r <= 1'b0;
      if (iCLEAR) begin
        // Clear beats a simultaneous commit; an ongoing press stays in PRESS so
        // it is still classified on release.
        pat_r         <= 5'd0;
        len_r         <= 3'd0;
        ovf_r         <= 1'b0;
        space_armed_r <= 1'b0;
        wipe_r        <= 1'b0;
        cursor_r      <= 5'd0;
        for (int i = 0; i < 32; i++) begin
          cell_r[i] <= ASCII_SPACE;
        end
        state_r <= (state_r == ST_PRESS) ? ST_PRESS : ST_IDLE;
      end else begin
        if (commit_en_s) begin
          char_r        <= commit_char_s;
          valid_r       <= 1'b1;
          space_armed_r <= (commit_char_s != ASCII_SPACE);
          if (wipe_r) begin
            for (int i = 0; i < 32; i++) begin
              cell_r[i] <= (i == 0) ? commit_char_s : ASCII_SPACE;
            end
            cursor_r <= 5'd1;
            wipe_r   <= 1'b0;
          end else if (cursor_r == 5'd31) begin
`ifdef MORSE_SCROLL_EN
            // Row 2 (with the new char in its last cell) moves up to row 1.
            for (int i = 0; i < 15; i++) begin
              cell_r[i] <= cell_r[i + 16];
            end
            cell_r[15] <= commit_char_s;
            for (int i = 16; i < 32; i++) begin
              cell_r[i] <= ASCII_SPACE;
            end
            cursor_r <= 5'd16;
`else
            cell_r[31] <= commit_char_s;
            cursor_r   <= 5'd0;
            wipe_r     <= 1'b1;
`endif
          end else begin
            cell_r[cursor_r] <= commit_char_s;
            cursor_r         <= cursor_r + 5'd1;
          end
        end else begin
          char_r <= char_r;
        end

        case (state_r)
          ST_IDLE: begin
            if (key_db_r) begin
              state_r <= ST_PRESS;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_PRESS: begin
            if (!key_db_r) begin
              if (ovf_r) begin
                ovf_r <= 1'b1;
              end else if (len_r == 3'd5) begin
                ovf_r <= 1'b1;
              end else begin
                pat_r[len_r] <= (dur_r < DOT_MAX) ? 1'b0 : 1'b1;
                len_r        <= len_r + 3'd1;
              end
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_PRESS;
            end
          end
          ST_GAP: begin
            if (key_db_r) begin
              state_r <= ST_PRESS;
            end else if (ms_r == CHAR_GAP) begin
              state_r <= ST_COMMIT;
            end else begin
              state_r <= ST_GAP;
            end
          end
          ST_COMMIT: begin
            pat_r   <= 5'd0;
            len_r   <= 3'd0;
            ovf_r   <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Flatten the cell array into the two row buses.
  always_comb begin
    row1 = '0;
    row2 = '0;
    for (int n = 0; n < 16; n++) begin
      row1[8*n +: 8] = cell_r[n];
      row2[8*n +: 8] = cell_r[n + 16];
    end
  end

  assign oCHAR       = char_r;
  assign oCHAR_VALID = valid_r;
  assign oCURSOR     = cursor_r;

endmodule
